// File: rtl/axil_host_bfm_core_if.sv
// AXI4-Lite bus bundle between the host BFM engine (master) and the device under test (slave).
interface axil_host_bfm_core_if #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_host_bfm_core.sv
// Host-side harness engine: single register commands to AXI4-Lite master transactions with timeout,
// a GPIO output register, synchronized GPIO inputs and an AXI-Stream beat/frame monitor.
module axil_host_bfm_core #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter int unsigned NUMB_INPUT_IO  = 1,
  parameter int unsigned NUMB_OUTPUT_IO = 3,
  parameter int unsigned T_DATA_WIDTH   = 64,
  parameter int unsigned T_USER_WIDTH   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      aclk,
  input  logic                      aclk_reset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      rsp_timeout,
  axil_host_bfm_core_if.master      m_axil,
  input  logic                      gpio_out_we,
  input  logic [NUMB_OUTPUT_IO-1:0] gpio_out_wdata,
  output logic [NUMB_OUTPUT_IO-1:0] output_reg,
  input  logic [NUMB_INPUT_IO-1:0]  input_io,
  output logic [NUMB_INPUT_IO-1:0]  gpio_in,
  output logic [NUMB_INPUT_IO-1:0]  gpio_in_rise,
  input  logic                      axis_ready_en,
  input  logic [T_DATA_WIDTH-1:0]   tdata,
  input  logic [T_USER_WIDTH-1:0]   tuser,
  input  logic                      tlast,
  input  logic                      tvalid,
  output logic                      tready,
  output logic [31:0]               beat_count,
  output logic [31:0]               frame_count,
  output logic [T_USER_WIDTH-1:0]   last_tuser,
  output logic [T_DATA_WIDTH-1:0]   last_tdata
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned TMO_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_WIDTH-1:0] TMO_LAST = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;
  logic                      rsp_timeout_q, rsp_timeout_d;
  logic [TMO_WIDTH-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [NUMB_OUTPUT_IO-1:0] output_reg_q, output_reg_d;
  logic [NUMB_INPUT_IO-1:0]  sync1_q, sync1_d;
  logic [NUMB_INPUT_IO-1:0]  gpio_in_q, gpio_in_d;
  logic [NUMB_INPUT_IO-1:0]  rise_q, rise_d;
  logic [31:0]               beat_count_q, beat_count_d;
  logic [31:0]               frame_count_q, frame_count_d;
  logic [T_USER_WIDTH-1:0]   last_tuser_q, last_tuser_d;
  logic [T_DATA_WIDTH-1:0]   last_tdata_q, last_tdata_d;

  logic                      tmo_hit_c;
  logic                      aw_done_c, w_done_c;
  logic                      finish_c, abort_c;
  logic [DATA_WIDTH-1:0]     fin_data_c;
  logic [1:0]                fin_resp_c;

  // Transaction FSM; a handshake seen in the timeout cycle wins over the abort.
  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    tmo_cnt_d     = tmo_cnt_q;
    finish_c      = 1'b0;
    abort_c       = 1'b0;
    fin_data_c    = '0;
    fin_resp_c    = 2'b00;
    tmo_hit_c     = (tmo_cnt_q >= TMO_LAST);
    aw_done_c     = !awvalid_q || m_axil.awready;
    w_done_c      = !wvalid_q || m_axil.wready;

    if (state_q != S_IDLE && state_q != S_DONE) begin
      tmo_cnt_d = tmo_cnt_q + TMO_WIDTH'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          tmo_cnt_d   = '0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          if (cmd_write) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WR: begin
        if (awvalid_q && m_axil.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axil.wready)   wvalid_d  = 1'b0;
        if (aw_done_c && w_done_c) begin
          state_d  = S_WR_RESP;
          bready_d = 1'b1;
        end else if (tmo_hit_c) begin
          abort_c = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (m_axil.bvalid) begin
          bready_d   = 1'b0;
          finish_c   = 1'b1;
          fin_resp_c = m_axil.bresp;
        end else if (tmo_hit_c) begin
          abort_c = 1'b1;
        end
      end
      S_RD_ADDR: begin
        if (m_axil.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end else if (tmo_hit_c) begin
          abort_c = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (m_axil.rvalid) begin
          rready_d   = 1'b0;
          finish_c   = 1'b1;
          fin_data_c = m_axil.rdata;
          fin_resp_c = m_axil.rresp;
        end else if (tmo_hit_c) begin
          abort_c = 1'b1;
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase

    if (finish_c) begin
      state_d       = S_DONE;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = fin_data_c;
      rsp_resp_d    = fin_resp_c;
      rsp_timeout_d = 1'b0;
    end
    if (abort_c) begin
      state_d       = S_DONE;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
    end
  end

  // GPIO register, input synchronizer/edge detect and stream monitor, all FSM-independent.
  always_comb begin
    output_reg_d  = gpio_out_we ? gpio_out_wdata : output_reg_q;
    sync1_d       = input_io;
    gpio_in_d     = sync1_q;
    rise_d        = sync1_q & ~gpio_in_q;
    beat_count_d  = beat_count_q;
    frame_count_d = frame_count_q;
    last_tuser_d  = last_tuser_q;
    last_tdata_d  = last_tdata_q;
    if (tvalid && axis_ready_en) begin
      beat_count_d = beat_count_q + 32'd1;
      last_tuser_d = tuser;
      last_tdata_d = tdata;
      if (tlast) frame_count_d = frame_count_q + 32'd1;
    end
  end

  always_ff @(posedge aclk or negedge aclk_reset_n) begin
    if (!aclk_reset_n) begin
      state_q       <= S_IDLE;
      cmd_ready_q   <= 1'b1;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      tmo_cnt_q     <= '0;
      output_reg_q  <= '0;
      sync1_q       <= '0;
      gpio_in_q     <= '0;
      rise_q        <= '0;
      beat_count_q  <= '0;
      frame_count_q <= '0;
      last_tuser_q  <= '0;
      last_tdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      tmo_cnt_q     <= tmo_cnt_d;
      output_reg_q  <= output_reg_d;
      sync1_q       <= sync1_d;
      gpio_in_q     <= gpio_in_d;
      rise_q        <= rise_d;
      beat_count_q  <= beat_count_d;
      frame_count_q <= frame_count_d;
      last_tuser_q  <= last_tuser_d;
      last_tdata_q  <= last_tdata_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign m_axil.awaddr  = addr_q;
  assign m_axil.awprot  = 3'b000;
  assign m_axil.awvalid = awvalid_q;
  assign m_axil.wdata   = wdata_q;
  assign m_axil.wstrb   = wstrb_q;
  assign m_axil.wvalid  = wvalid_q;
  assign m_axil.bready  = bready_q;
  assign m_axil.araddr  = addr_q;
  assign m_axil.arprot  = 3'b000;
  assign m_axil.arvalid = arvalid_q;
  assign m_axil.rready  = rready_q;
  assign output_reg     = output_reg_q;
  assign gpio_in        = gpio_in_q;
  assign gpio_in_rise   = rise_q;
  assign tready         = axis_ready_en;
  assign beat_count     = beat_count_q;
  assign frame_count    = frame_count_q;
  assign last_tuser     = last_tuser_q;
  assign last_tdata     = last_tdata_q;

endmodule

// File: tb/tb_axil_host_bfm_core.sv
// Directed self-checking bench for axil_host_bfm_core; the AXI-Lite slave side is driven by hand.
module tb_axil_host_bfm_core;

  logic        aclk = 1'b0;
  logic        aclk_reset_n;
  logic        cmd_valid, cmd_write;
  logic        cmd_ready;
  logic [10:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        gpio_out_we;
  logic [2:0]  gpio_out_wdata, output_reg;
  logic [0:0]  input_io, gpio_in, gpio_in_rise;
  logic        axis_ready_en, tlast, tvalid, tready;
  logic [63:0] tdata, last_tdata;
  logic [3:0]  tuser, last_tuser;
  logic [31:0] beat_count, frame_count;

  int checks = 0;
  int failures = 0;

  axil_host_bfm_core_if #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) axil ();

  axil_host_bfm_core #(
    .DATA_WIDTH(32), .ADDR_WIDTH(11), .NUMB_INPUT_IO(1), .NUMB_OUTPUT_IO(3),
    .T_DATA_WIDTH(64), .T_USER_WIDTH(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .aclk(aclk), .aclk_reset_n(aclk_reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axil(axil),
    .gpio_out_we(gpio_out_we), .gpio_out_wdata(gpio_out_wdata), .output_reg(output_reg),
    .input_io(input_io), .gpio_in(gpio_in), .gpio_in_rise(gpio_in_rise),
    .axis_ready_en(axis_ready_en), .tdata(tdata), .tuser(tuser), .tlast(tlast),
    .tvalid(tvalid), .tready(tready),
    .beat_count(beat_count), .frame_count(frame_count),
    .last_tuser(last_tuser), .last_tdata(last_tdata)
  );

  always #5 aclk = ~aclk;

  task automatic clear_slave();
    axil.awready = 1'b0; axil.wready = 1'b0; axil.bvalid = 1'b0; axil.bresp = 2'b00;
    axil.arready = 1'b0; axil.rvalid = 1'b0; axil.rdata = 32'h0; axil.rresp = 2'b00;
  endtask

  // Presents one command for exactly one clock edge; returns #1 after the accepting edge.
  task automatic issue_cmd(input logic wr, input logic [10:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    @(posedge aclk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(posedge aclk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    aclk_reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    gpio_out_we = 1'b0; gpio_out_wdata = '0; input_io = '0;
    axis_ready_en = 1'b0; tdata = '0; tuser = '0; tlast = 1'b0; tvalid = 1'b0;
    clear_slave();
    #12;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if ({axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready} !== 5'b0) begin
      failures++; $display("FAIL reset_axi_valids got=%b exp=00000",
        {axil.awvalid, axil.wvalid, axil.bready, axil.arvalid, axil.rready}); end
    checks++; if ({rsp_valid, rsp_timeout, rsp_resp} !== 4'b0) begin failures++;
      $display("FAIL reset_rsp got=%b exp=0000", {rsp_valid, rsp_timeout, rsp_resp}); end
    checks++; if ({axil.awprot, axil.arprot} !== 6'b0) begin failures++;
      $display("FAIL reset_prot got=%b exp=000000", {axil.awprot, axil.arprot}); end
    checks++; if ({output_reg, gpio_in, gpio_in_rise, tready} !== 6'b0) begin failures++;
      $display("FAIL reset_gpio got=%b exp=000000", {output_reg, gpio_in, gpio_in_rise, tready}); end
    checks++; if ({beat_count, frame_count} !== 64'h0) begin failures++;
      $display("FAIL reset_counts got=%h exp=0", {beat_count, frame_count}); end
    @(posedge aclk); #1;
    aclk_reset_n = 1'b1;
  endtask

  task automatic test_write_basic();
    int aw_cnt = 0, w_cnt = 0, rsp_cnt = 0, rsp_at = 0, rdy_at = 0;
    logic [10:0] aw_addr = '0;
    logic [31:0] w_data = '0;
    logic [3:0]  w_strb = '0;
    logic [1:0]  resp = 2'b11;
    logic        tmo = 1'b1;
    axil.awready = 1'b1; axil.wready = 1'b1; axil.bvalid = 1'b1; axil.bresp = 2'b00;
    issue_cmd(1'b1, 11'h040, 32'h0000_00A5, 4'hF);
    for (int i = 1; i <= 8; i++) begin
      @(negedge aclk);
      if (axil.awvalid) begin aw_cnt++; aw_addr = axil.awaddr; end
      if (axil.wvalid) begin w_cnt++; w_data = axil.wdata; w_strb = axil.wstrb; end
      if (rsp_valid) begin rsp_cnt++; rsp_at = i; resp = rsp_resp; tmo = rsp_timeout; end
      if (cmd_ready && rdy_at == 0) rdy_at = i;
      @(posedge aclk); #1;
    end
    clear_slave();
    checks++; if (aw_cnt != 1 || w_cnt != 1) begin failures++;
      $display("FAIL wr_valid_cycles got aw=%0d w=%0d exp aw=1 w=1", aw_cnt, w_cnt); end
    checks++; if (aw_addr !== 11'h040 || w_data !== 32'hA5 || w_strb !== 4'hF) begin failures++;
      $display("FAIL wr_payload got addr=%h data=%h strb=%h exp 040/000000a5/f", aw_addr, w_data, w_strb); end
    checks++; if (rsp_cnt != 1 || rsp_at != 3 || resp !== 2'b00 || tmo !== 1'b0) begin failures++;
      $display("FAIL wr_rsp got cnt=%0d at=%0d resp=%b tmo=%b exp 1/3/00/0", rsp_cnt, rsp_at, resp, tmo); end
    checks++; if (rdy_at != 4) begin failures++;
      $display("FAIL wr_ready_latency got=%0d exp=4", rdy_at); end
  endtask

  task automatic test_write_w_first();
    int aw_cnt = 0, w_cnt = 0, rsp_cnt = 0, rsp_at = 0, rdy_at = 0;
    logic [1:0] resp = 2'b11;
    axil.awready = 1'b0; axil.wready = 1'b1; axil.bvalid = 1'b1; axil.bresp = 2'b01;
    issue_cmd(1'b1, 11'h104, 32'hDEAD_0001, 4'h3);
    for (int i = 1; i <= 10; i++) begin
      axil.awready = (i >= 4);
      @(negedge aclk);
      if (axil.awvalid) aw_cnt++;
      if (axil.wvalid) w_cnt++;
      if (rsp_valid) begin rsp_cnt++; rsp_at = i; resp = rsp_resp; end
      if (cmd_ready && rdy_at == 0) rdy_at = i;
      @(posedge aclk); #1;
    end
    clear_slave();
    checks++; if (aw_cnt != 4 || w_cnt != 1) begin failures++;
      $display("FAIL wfirst_valid_cycles got aw=%0d w=%0d exp aw=4 w=1", aw_cnt, w_cnt); end
    checks++; if (rsp_cnt != 1 || rsp_at != 6 || resp !== 2'b01) begin failures++;
      $display("FAIL wfirst_rsp got cnt=%0d at=%0d resp=%b exp 1/6/01", rsp_cnt, rsp_at, resp); end
    checks++; if (rdy_at != 7) begin failures++;
      $display("FAIL wfirst_ready got=%0d exp=7", rdy_at); end
  endtask

  task automatic test_read();
    int ar_cnt = 0, r_cnt = 0, rsp_cnt = 0, rsp_at = 0, rdy_at = 0;
    logic [10:0] ar_addr = 11'h7FF;
    logic [31:0] rd = '0;
    logic [1:0]  resp = 2'b11;
    axil.arready = 1'b1; axil.rvalid = 1'b0; axil.rdata = 32'h0058_0000; axil.rresp = 2'b00;
    issue_cmd(1'b0, 11'h000, 32'h0, 4'h0);
    for (int i = 1; i <= 9; i++) begin
      axil.rvalid = (i >= 4);
      @(negedge aclk);
      if (axil.arvalid) begin ar_cnt++; ar_addr = axil.araddr; end
      if (axil.rready) r_cnt++;
      if (rsp_valid) begin rsp_cnt++; rsp_at = i; rd = rsp_rdata; resp = rsp_resp; end
      if (cmd_ready && rdy_at == 0) rdy_at = i;
      @(posedge aclk); #1;
    end
    clear_slave();
    checks++; if (ar_cnt != 1 || ar_addr !== 11'h000 || r_cnt != 3) begin failures++;
      $display("FAIL rd_handshake got ar=%0d addr=%h rready=%0d exp 1/000/3", ar_cnt, ar_addr, r_cnt); end
    checks++; if (rsp_cnt != 1 || rsp_at != 5 || rd !== 32'h0058_0000 || resp !== 2'b00) begin failures++;
      $display("FAIL rd_rsp got cnt=%0d at=%0d data=%h resp=%b exp 1/5/00580000/00", rsp_cnt, rsp_at, rd, resp); end
    checks++; if (rdy_at != 6) begin failures++; $display("FAIL rd_ready got=%0d exp=6", rdy_at); end
    @(negedge aclk);
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0058_0000) begin failures++;
      $display("FAIL rd_hold got valid=%b data=%h exp 0/00580000", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_timeout();
    int ar_cnt = 0, last_ar = 0, rsp_cnt = 0, rsp_at = 0, rdy_at = 0;
    logic [31:0] rd = 32'hFFFF_FFFF;
    logic [1:0]  resp = 2'b00;
    logic        tmo = 1'b0;
    clear_slave();
    issue_cmd(1'b0, 11'h010, 32'h0, 4'h0);
    for (int i = 1; i <= 22; i++) begin
      @(negedge aclk);
      if (axil.arvalid) begin ar_cnt++; last_ar = i; end
      if (rsp_valid) begin rsp_cnt++; rsp_at = i; rd = rsp_rdata; resp = rsp_resp; tmo = rsp_timeout; end
      if (cmd_ready && rdy_at == 0) rdy_at = i;
      @(posedge aclk); #1;
    end
    checks++; if (ar_cnt != 16 || last_ar != 16) begin failures++;
      $display("FAIL tmo_arvalid got cycles=%0d last=%0d exp 16/16", ar_cnt, last_ar); end
    checks++; if (rsp_cnt != 1 || rsp_at != 17 || resp !== 2'b10 || tmo !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("FAIL tmo_rsp got cnt=%0d at=%0d resp=%b tmo=%b data=%h exp 1/17/10/1/0",
        rsp_cnt, rsp_at, resp, tmo, rd); end
    checks++; if (rdy_at != 18) begin failures++; $display("FAIL tmo_idle got=%0d exp=18", rdy_at); end
  endtask

  task automatic test_back_to_back();
    int rsp_cnt = 0;
    logic [2:0]  gpio_mid = '0;
    logic [1:0]  resp = 2'b11;
    logic        tmo = 1'b1;
    logic [31:0] rd = 32'hFFFF_FFFF;
    axil.awready = 1'b1; axil.wready = 1'b1; axil.bvalid = 1'b1; axil.bresp = 2'b00;
    issue_cmd(1'b1, 11'h008, 32'h1234_5678, 4'hF);
    for (int i = 1; i <= 6; i++) begin
      gpio_out_we = (i == 1); gpio_out_wdata = 3'b010;
      @(negedge aclk);
      if (i == 2) gpio_mid = output_reg;
      if (rsp_valid) begin rsp_cnt++; resp = rsp_resp; tmo = rsp_timeout; rd = rsp_rdata; end
      @(posedge aclk); #1;
    end
    gpio_out_we = 1'b0;
    clear_slave();
    checks++; if (rsp_cnt != 1 || resp !== 2'b00 || tmo !== 1'b0 || rd !== 32'h0) begin failures++;
      $display("FAIL b2b_rsp got cnt=%0d resp=%b tmo=%b data=%h exp 1/00/0/0", rsp_cnt, resp, tmo, rd); end
    checks++; if (gpio_mid !== 3'b010) begin failures++;
      $display("FAIL b2b_gpio_inflight got=%b exp=010", gpio_mid); end
  endtask

  task automatic test_gpio();
    @(posedge aclk); #1;
    gpio_out_we = 1'b1; gpio_out_wdata = 3'b101;
    @(negedge aclk);
    checks++; if (output_reg !== 3'b010) begin failures++;
      $display("FAIL gpio_before_load got=%b exp=010", output_reg); end
    @(posedge aclk); #1;
    gpio_out_we = 1'b0;
    checks++; if (output_reg !== 3'b101) begin failures++;
      $display("FAIL gpio_load got=%b exp=101", output_reg); end
    input_io = 1'b1;
    @(posedge aclk); @(negedge aclk);
    checks++; if (gpio_in !== 1'b0 || gpio_in_rise !== 1'b0) begin failures++;
      $display("FAIL gpio_sync_1 got in=%b rise=%b exp 0/0", gpio_in, gpio_in_rise); end
    @(posedge aclk); @(negedge aclk);
    checks++; if (gpio_in !== 1'b1 || gpio_in_rise !== 1'b1) begin failures++;
      $display("FAIL gpio_sync_2 got in=%b rise=%b exp 1/1", gpio_in, gpio_in_rise); end
    @(posedge aclk); @(negedge aclk);
    checks++; if (gpio_in !== 1'b1 || gpio_in_rise !== 1'b0) begin failures++;
      $display("FAIL gpio_sync_3 got in=%b rise=%b exp 1/0", gpio_in, gpio_in_rise); end
  endtask

  task automatic test_stream();
    @(posedge aclk); #1;
    axis_ready_en = 1'b1;
    #1;
    checks++; if (tready !== 1'b1) begin failures++; $display("FAIL axis_tready_on got=%b exp=1", tready); end
    for (int b = 0; b < 4; b++) begin
      tvalid = 1'b1; tdata = 64'h0123_4567_0000_0000 | 64'(b);
      tuser = (b == 3) ? 4'h2 : 4'h5; tlast = (b == 3);
      @(posedge aclk); #1;
    end
    tvalid = 1'b0; tlast = 1'b0;
    checks++; if (beat_count !== 32'd4 || frame_count !== 32'd1) begin failures++;
      $display("FAIL axis_counts got beats=%0d frames=%0d exp 4/1", beat_count, frame_count); end
    checks++; if (last_tuser !== 4'h2 || last_tdata !== 64'h0123_4567_0000_0003) begin failures++;
      $display("FAIL axis_last got tuser=%h tdata=%h exp 2/0123456700000003", last_tuser, last_tdata); end
    axis_ready_en = 1'b0;
    #1;
    checks++; if (tready !== 1'b0) begin failures++; $display("FAIL axis_tready_off got=%b exp=0", tready); end
    for (int b = 0; b < 3; b++) begin
      tvalid = 1'b1; tlast = 1'b1; tuser = 4'hF; tdata = 64'hFFFF_FFFF_FFFF_FFFF;
      @(posedge aclk); #1;
    end
    tvalid = 1'b0; tlast = 1'b0;
    checks++; if (beat_count !== 32'd4 || frame_count !== 32'd1 || last_tuser !== 4'h2) begin failures++;
      $display("FAIL axis_blocked got beats=%0d frames=%0d tuser=%h exp 4/1/2", beat_count, frame_count, last_tuser); end
  endtask

  task automatic test_reset_mid();
    clear_slave();
    issue_cmd(1'b0, 11'h020, 32'h0, 4'h0);
    @(posedge aclk); @(posedge aclk);
    #2;
    checks++; if (axil.arvalid !== 1'b1) begin failures++;
      $display("FAIL rstmid_pre_arvalid got=%b exp=1", axil.arvalid); end
    aclk_reset_n = 1'b0;
    #1;
    checks++; if (axil.arvalid !== 1'b0 || cmd_ready !== 1'b1) begin failures++;
      $display("FAIL rstmid_fsm got arvalid=%b cmd_ready=%b exp 0/1", axil.arvalid, cmd_ready); end
    checks++; if (output_reg !== 3'b000 || beat_count !== 32'd0 || frame_count !== 32'd0) begin failures++;
      $display("FAIL rstmid_clear got gpio=%b beats=%0d frames=%0d exp 000/0/0", output_reg, beat_count, frame_count); end
    @(posedge aclk); #1;
    aclk_reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_write_w_first();
    test_read();
    test_timeout();
    test_back_to_back();
    test_gpio();
    test_stream();
    test_reset_mid();
    repeat (2) @(posedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
